team_06_effect_mux: RTL and testbench
=====================================

Name: team_06_effect_mux

Overview:
- Output-stage effect selector for the team_06 audio path.
- Picks one of four 8-bit sample streams (dry, echo, reverb, soft) according to a 2-bit selector and registers the result as final_audio.
- Optionally crossfades linearly between the old and new source when the selector changes, so switching effects does not click.
- Sits after the effect blocks, directly before the audio output stage.

Parameters:
- WIDTH, 8: sample width in bits (unsigned) for all audio ports.
- FADE_SHIFT, 0: crossfade length exponent. Fade lasts 2^FADE_SHIFT cycles; 0 disables fading (pure registered mux).

Ports:
- clk  input  1  system clock, rising-edge active
- nRst  input  1  asynchronous active-low reset
- selector  input  2  source select: 0=dry_audio, 1=echo_out, 2=reverb_out, 3=soft_out
- dry_audio  input  WIDTH  unprocessed sample
- echo_out  input  WIDTH  echo effect sample
- reverb_out  input  WIDTH  reverb effect sample
- soft_out  input  WIDTH  soft/attenuated effect sample
- final_audio  output  WIDTH  selected (or crossfading) sample, registered

Behaviour:
- Interface: one clock (clk); reset nRst is asynchronous and active-low.
- Reset (nRst=0, immediate, independent of clk):
  - final_audio=0
  - cur_sel=0, prev_sel=0, fade count=0
  - state=IDLE
- src(s) denotes the live input selected by code s, sampled combinationally on the current cycle.

FADE_SHIFT=0:
- Every rising edge: final_audio <= src(selector).
- Latency is exactly 1 cycle; no state machine activity. cur_sel tracks selector.

FADE_SHIFT>0, two states, IDLE and FADE:
- IDLE, selector==cur_sel:
  - final_audio <= src(cur_sel).
- IDLE, selector!=cur_sel:
  - prev_sel<=cur_sel; cur_sel<=selector; count<=1; final_audio <= src(old cur_sel); go to FADE.
- FADE:
  - a=src(prev_sel), b=src(cur_sel).
  - final_audio <= a + ((b-a)*count) >>> FADE_SHIFT.
  - b-a is a signed WIDTH+1 value; the product is signed; the shift is arithmetic (floor).
  - count<=count+1.
- FADE, count==2^FADE_SHIFT:
  - The formula yields exactly b. Write b, clear count, go to IDLE.
- Selector changes while in FADE are ignored. If selector still differs from cur_sel on return to IDLE, a new fade starts on that IDLE cycle.
- Result always lies between a and b inclusive, so no overflow or saturation logic is required; the output is the low WIDTH bits.
- Inputs may change every cycle; the fade always uses the live sample values, not captured ones.
- Reset asserted mid-fade aborts the fade. After release the block is in IDLE with cur_sel=0.

Test Plan:
1. FADE_SHIFT=0, reset asserted → final_audio=0. Release, selector=0, dry=1, others 0 → final_audio=1 after one clk edge.
2. FADE_SHIFT=0, sweep selector 1,2,3 with echo=1, reverb=1, soft=1 respectively (the other inputs 0) → final_audio=1 one cycle after each change. Also drive distinct values (dry=10, echo=20, reverb=30, soft=40) → output tracks the selected value with 1-cycle latency.
3. FADE_SHIFT=2, dry=0, echo=200, selector 0→1 → successive final_audio values 0, 50, 100, 150, 200, then holds 200 in IDLE.
4. FADE_SHIFT=2, echo=200, reverb=0, selector 1→2 (downward fade) → 200, 150, 100, 50, 0.
5. FADE_SHIFT=2, selector changed again mid-fade (0→1, then →3 on the second fade cycle):
   - The first fade completes to echo.
   - Next cycle a new fade from echo toward soft begins.
6. Assert nRst asynchronously mid-fade (between edges) → final_audio=0 immediately. After release with selector=0, output follows dry_audio with 1-cycle latency and no fade.

Source files
------------

// File: rtl/team_06_effect_mux.sv
// Output-stage effect selector: registered 4:1 mux of audio streams with an
// optional linear crossfade between the old and new source on selector change.
module team_06_effect_mux #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned FADE_SHIFT = 0
) (
  input  logic             clk,
  input  logic             nRst,
  input  logic [1:0]       selector,
  input  logic [WIDTH-1:0] dry_audio,
  input  logic [WIDTH-1:0] echo_out,
  input  logic [WIDTH-1:0] reverb_out,
  input  logic [WIDTH-1:0] soft_out,
  output logic [WIDTH-1:0] final_audio
);

  localparam int unsigned CNT_W  = FADE_SHIFT + 1;
  localparam int unsigned PROD_W = WIDTH + FADE_SHIFT + 3;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(2 ** FADE_SHIFT);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_FADE = 1'b1
  } state_t;

  state_t             r_state;
  logic [1:0]         r_cur_sel;
  logic [1:0]         r_prev_sel;
  logic [CNT_W-1:0]   r_count;
  logic [WIDTH-1:0]   r_final;

  state_t             w_state_nxt;
  logic [1:0]         w_cur_nxt;
  logic [1:0]         w_prev_nxt;
  logic [CNT_W-1:0]   w_count_nxt;
  logic [WIDTH-1:0]   w_final_nxt;

  logic [WIDTH-1:0]   w_src [4];
  logic [WIDTH-1:0]   w_a;
  logic [WIDTH-1:0]   w_b;
  logic signed [PROD_W-1:0] w_diff;
  logic signed [PROD_W-1:0] w_prod;
  logic signed [PROD_W-1:0] w_mix;
  logic [WIDTH-1:0]   w_mix_lo;

  assign w_src[0] = dry_audio;
  assign w_src[1] = echo_out;
  assign w_src[2] = reverb_out;
  assign w_src[3] = soft_out;

  // Live samples of the outgoing (a) and incoming (b) sources.
  assign w_a = w_src[r_prev_sel];
  assign w_b = w_src[r_cur_sel];

  // a + floor((b-a)*count / 2^FADE_SHIFT); always lies between a and b.
  assign w_diff   = $signed(PROD_W'(w_b)) - $signed(PROD_W'(w_a));
  assign w_prod   = w_diff * $signed(PROD_W'(r_count));
  assign w_mix    = (w_prod >>> FADE_SHIFT) + $signed(PROD_W'(w_a));
  assign w_mix_lo = WIDTH'(w_mix);

  assign final_audio = r_final;

  // State and datapath registers.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      r_state    <= ST_IDLE;
      r_cur_sel  <= 2'd0;
      r_prev_sel <= 2'd0;
      r_count    <= '0;
      r_final    <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_cur_sel  <= w_cur_nxt;
      r_prev_sel <= w_prev_nxt;
      r_count    <= w_count_nxt;
      r_final    <= w_final_nxt;
    end
  end

  // Next-state and output selection.
  always_comb begin
    w_state_nxt = r_state;
    w_cur_nxt   = r_cur_sel;
    w_prev_nxt  = r_prev_sel;
    w_count_nxt = r_count;
    w_final_nxt = r_final;

    if (FADE_SHIFT == 0) begin
      w_state_nxt = ST_IDLE;
      w_cur_nxt   = selector;
      w_final_nxt = w_src[selector];
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_final_nxt = w_src[r_cur_sel];
          if (selector != r_cur_sel) begin
            w_prev_nxt  = r_cur_sel;
            w_cur_nxt   = selector;
            w_count_nxt = CNT_W'(1);
            w_state_nxt = ST_FADE;
          end
        end
        ST_FADE: begin
          // Selector changes are ignored until the fade completes.
          if (r_count == CNT_LAST) begin
            w_final_nxt = w_b;
            w_count_nxt = '0;
            w_state_nxt = ST_IDLE;
          end else begin
            w_final_nxt = w_mix_lo;
            w_count_nxt = r_count + CNT_W'(1);
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_count_nxt = '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_team_06_effect_mux.sv
// Scoreboard bench for team_06_effect_mux: a plain mux instance and a
// crossfading instance (FADE_SHIFT=2) checked against a behavioural model.
module tb_team_06_effect_mux;

  logic       clk;
  logic       nRst;
  logic [1:0] selector;
  logic [7:0] dry_audio, echo_out, reverb_out, soft_out;
  logic [7:0] out0, out2;

  int n_cmp = 0;
  int n_bad = 0;
  bit started = 0;

  int q0[$];
  int q2[$];

  // Model state for the fading instance.
  int m_cur  = 0;
  int m_prev = 0;
  int m_k    = 0;

  team_06_effect_mux #(.WIDTH(8), .FADE_SHIFT(0)) u_dut0 (
    .clk(clk), .nRst(nRst), .selector(selector),
    .dry_audio(dry_audio), .echo_out(echo_out),
    .reverb_out(reverb_out), .soft_out(soft_out),
    .final_audio(out0)
  );

  team_06_effect_mux #(.WIDTH(8), .FADE_SHIFT(2)) u_dut2 (
    .clk(clk), .nRst(nRst), .selector(selector),
    .dry_audio(dry_audio), .echo_out(echo_out),
    .reverb_out(reverb_out), .soft_out(soft_out),
    .final_audio(out2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Expected outputs after the next rising edge, from the current inputs.
  task automatic model_push();
    int src[4];
    int e2;
    int p;
    src[0] = int'(dry_audio);
    src[1] = int'(echo_out);
    src[2] = int'(reverb_out);
    src[3] = int'(soft_out);
    if (!nRst) begin
      m_cur = 0; m_prev = 0; m_k = 0;
      q0.push_back(0);
      q2.push_back(0);
      return;
    end
    q0.push_back(src[int'(selector)]);
    if (m_k == 0) begin
      e2 = src[m_cur];
      if (int'(selector) != m_cur) begin
        m_prev = m_cur;
        m_cur  = int'(selector);
        m_k    = 1;
      end
    end else begin
      // Linear interpolation over 4 steps, rounded toward minus infinity.
      p  = (src[m_cur] - src[m_prev]) * m_k;
      e2 = src[m_prev] + int'($floor(real'(p) / 4.0));
      m_k = (m_k == 4) ? 0 : m_k + 1;
    end
    q2.push_back(e2);
  endtask

  task automatic cyc(input int s, input int d, input int e, input int r,
                     input int so, input logic rn);
    @(negedge clk);
    selector   = 2'(s);
    dry_audio  = 8'(d);
    echo_out   = 8'(e);
    reverb_out = 8'(r);
    soft_out   = 8'(so);
    nRst       = rn;
    started    = 1'b1;
    model_push();
  endtask

  // Monitor: one output per rising edge on each instance.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (q0.size() == 0 || q2.size() == 0) begin
        if (started) check("queue_underflow", 0, 1);
      end else begin
        check("mux_out", int'(out0), q0.pop_front());
        check("fade_out", int'(out2), q2.pop_front());
      end
    end
  end

  initial begin
    int s;
    selector = 2'd0; dry_audio = '0; echo_out = '0; reverb_out = '0; soft_out = '0;
    nRst = 1'b1;
    #1 nRst = 1'b0;
    #1;
    check("reset_mux", int'(out0), 0);
    check("reset_fade", int'(out2), 0);

    // Basic selection with the plain mux.
    cyc(0, 1, 0, 0, 0, 1'b0);
    cyc(0, 1, 0, 0, 0, 1'b1);
    cyc(0, 1, 0, 0, 0, 1'b1);
    cyc(1, 0, 1, 0, 0, 1'b1);
    cyc(2, 0, 0, 1, 0, 1'b1);
    cyc(3, 0, 0, 0, 1, 1'b1);
    for (int i = 0; i < 8; i++) cyc(i % 4, 10, 20, 30, 40, 1'b1);

    // Upward fade dry(0) -> echo(200), then downward fade echo -> reverb(0).
    for (int i = 0; i < 8; i++) cyc(0, 0, 200, 0, 0, 1'b1);
    for (int i = 0; i < 7; i++) cyc(1, 0, 200, 0, 0, 1'b1);
    for (int i = 0; i < 7; i++) cyc(2, 0, 200, 0, 0, 1'b1);

    // Selector moves again mid-fade; second fade follows the first.
    for (int i = 0; i < 6; i++) cyc(0, 0, 200, 0, 120, 1'b1);
    cyc(1, 0, 200, 0, 120, 1'b1);
    cyc(1, 0, 200, 0, 120, 1'b1);
    for (int i = 0; i < 12; i++) cyc(3, 0, 200, 0, 120, 1'b1);

    // Asynchronous reset between edges while fading.
    for (int i = 0; i < 6; i++) cyc(0, 10, 250, 0, 0, 1'b1);
    cyc(1, 10, 250, 0, 0, 1'b1);
    cyc(1, 10, 250, 0, 0, 1'b1);
    @(negedge clk);
    #1 nRst = 1'b0;
    #1;
    check("async_reset_mux", int'(out0), 0);
    check("async_reset_fade", int'(out2), 0);
    model_push();
    cyc(1, 10, 250, 0, 0, 1'b0);
    for (int i = 0; i < 6; i++) cyc(0, 10 + 7 * i, 250, 0, 0, 1'b1);

    // Random traffic with live-changing samples and occasional resets.
    s = 0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) s = int'($urandom_range(0, 3));
      cyc(s, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
          int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
          ($urandom_range(0, 99) != 0));
    end

    @(negedge clk);
    started = 1'b0;
    check("queue_drained", q0.size() + q2.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
